// File: rtl/issue_scoreboard.sv
// In-order issue controller: holds one decoded instruction, tracks pending
// register writes in a busy-bit scoreboard, and stalls on RAW/WAW hazards,
// on the in-flight write limit and on unresolved control flow.

package issue_pkg;

    typedef enum logic [5:0] {
        INVALID_I = 6'd0,
        LUI_I, AUIPC_I, JAL_I, JALR_I,
        BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
        LW_I, SW_I,
        ADDI_I, SLTI_I, XORI_I, ORI_I, ANDI_I, SLLI_I, SRLI_I, SRAI_I,
        ADD_I, SUB_I, SLL_I, SLT_I, SLTU_I, XOR_I, SRL_I, SRA_I, OR_I, AND_I
    } op_e;

    typedef struct packed {
        op_e         decoded_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm_val;
        logic        is_br;
        logic        is_jmp;
        logic        rd_mem;
        logic        wr_mem;
        logic        wr_reg;
    } decoded_instr_t;

    // rs1 is read by every legal op except the ones that build from PC/imm only
    function automatic logic uses_rs1(input op_e op);
        case (op)
            INVALID_I, LUI_I, AUIPC_I, JAL_I: uses_rs1 = 1'b0;
            default:                          uses_rs1 = 1'b1;
        endcase
    endfunction

    // rs2 is read by register-register ALU ops, stores and branches
    function automatic logic uses_rs2(input op_e op);
        case (op)
            ADD_I, SUB_I, SLL_I, SLT_I, SLTU_I, XOR_I, SRL_I, SRA_I, OR_I, AND_I,
            SW_I,
            BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I: uses_rs2 = 1'b1;
            default:                                    uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  decoded_instr_t       dec_instr,
    input  logic [31:0]          dec_pc,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output decoded_instr_t       iss_instr,
    output logic [31:0]          iss_pc,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 br_resolve,
    input  logic                 flush,
    output logic                 illegal_instr,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic [CNT_BITS-1:0]  stall_cycles
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_e;

    state_e                state_q;
    decoded_instr_t        instr_q;
    logic [31:0]           pc_q;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic [CNT_BITS-1:0]   stall_q;
    logic                  illegal_q;

    logic writes_s, hazard_s, full_s, iss_valid_s, fire_s, held_cf_s;
    logic dec_ready_s, accept_s, accept_legal_s, inc_s, dec_s;

    // Hazard, issue and accept qualification from registered state only
    always_comb begin
        // A write to x0 never occupies the scoreboard nor an in-flight slot,
        // since no writeback will ever retire it.
        writes_s    = instr_q.wr_reg && (instr_q.rd != 5'd0);
        hazard_s    = (uses_rs1(instr_q.decoded_op) && busy_q[instr_q.rs1]) ||
                      (uses_rs2(instr_q.decoded_op) && busy_q[instr_q.rs2]) ||
                      (instr_q.wr_reg && busy_q[instr_q.rd]);
        full_s      = writes_s && (inflight_q == IW'(MAX_INFLIGHT));
        iss_valid_s = (state_q == ST_HOLD) && !hazard_s && !full_s && !flush;
        fire_s      = iss_valid_s && iss_ready;
        held_cf_s   = instr_q.is_br || instr_q.is_jmp;
        // A branch leaving the hold register parks us in BR_WAIT, so nothing
        // may be accepted behind it in the same cycle.
        dec_ready_s = !flush && ((state_q == ST_EMPTY) || (fire_s && !held_cf_s));
        accept_s    = dec_valid && dec_ready_s;
        accept_legal_s = accept_s && (dec_instr.decoded_op != INVALID_I);
        inc_s       = fire_s && writes_s;
        dec_s       = wb_valid && (inflight_q != {IW{1'b0}});
    end

    // Next scoreboard and in-flight count: clear on writeback, set on issue
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (inc_s) begin
            busy_d[instr_q.rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
        case ({inc_s, dec_s})
            2'b10:   inflight_d = inflight_q + {{(IW-1){1'b0}}, 1'b1};
            2'b01:   inflight_d = inflight_q - {{(IW-1){1'b0}}, 1'b1};
            default: inflight_d = inflight_q;
        endcase
    end

    // Issue FSM and hold register; flush overrides accept and issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            pc_q    <= 32'd0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            pc_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_legal_s) begin
                        state_q <= ST_HOLD;
                        instr_q <= dec_instr;
                        pc_q    <= dec_pc;
                    end
                end
                ST_HOLD: begin
                    if (fire_s) begin
                        if (held_cf_s) begin
                            state_q <= ST_BR_WAIT;
                        end else if (accept_legal_s) begin
                            state_q <= ST_HOLD;
                            instr_q <= dec_instr;
                            pc_q    <= dec_pc;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolve) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Scoreboard, in-flight count, stall counter and illegal pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= {NUM_REGS{1'b0}};
            inflight_q <= {IW{1'b0}};
            stall_q    <= {CNT_BITS{1'b0}};
            illegal_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            illegal_q  <= accept_s && (dec_instr.decoded_op == INVALID_I);
            if ((state_q == ST_HOLD) && !iss_valid_s && (stall_q != {CNT_BITS{1'b1}})) begin
                stall_q <= stall_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    assign dec_ready     = dec_ready_s;
    assign iss_valid     = iss_valid_s;
    assign iss_instr     = instr_q;
    assign iss_pc        = pc_q;
    assign illegal_instr = illegal_q;
    assign busy_vec      = busy_q;
    assign stall_cycles  = stall_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
In-order issue controller between the decode stage and the execute stage. It holds one decoded instruction and tracks pending register writes in a busy-bit scoreboard. It stalls on RAW/WAW hazards, on a full in-flight limit, and on unresolved control flow. It issues through a valid/ready handshake and pulses a flag for illegal instructions.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never busy.
MAX_INFLIGHT, 4, maximum outstanding register-writing instructions (issued, not yet written back).
CNT_BITS, 32, width of the stall performance counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
dec_valid  in  1  decode presents an instruction.
dec_ready  out  1  controller accepts it this cycle.
dec_instr  in  decoded_instr_t  decoded fields (decoded_op, rs1, rs2, rd, imm_val, is_br, is_jmp, rd_mem, wr_mem, wr_reg).
dec_pc  in  32  PC of the decoded instruction.
iss_valid  out  1  held instruction is issuable.
iss_ready  in  1  execute accepts it.
iss_instr  out  decoded_instr_t  held instruction.
iss_pc  out  32  held PC.
wb_valid  in  1  writeback retires a register write.
wb_rd  in  5  destination register of the retiring write; never 0 when wb_valid=1.
br_resolve  in  1  the outstanding branch/jump has resolved.
flush  in  1  discard held instruction and control-flow wait.
illegal_instr  out  1  one-cycle pulse when an INVALID_I instruction is accepted.
busy_vec  out  NUM_REGS  scoreboard contents (debug).
stall_cycles  out  CNT_BITS  count of cycles with the held instruction blocked.

Behaviour:
- Reset (rst=1 at posedge): state=EMPTY, held regs cleared, busy_vec=0, inflight=0, stall_cycles=0, iss_valid=0, illegal_instr=0.
- States:
  - EMPTY: no instruction held.
  - HOLD: one instruction held.
  - BR_WAIT: a branch/jump has issued; waiting for br_resolve.
- dec_ready = !flush && (state==EMPTY || (state==HOLD && iss_valid && iss_ready)). It is 0 in BR_WAIT.
- Accept (dec_valid && dec_ready):
  - decoded_op==INVALID_I: pulse illegal_instr next cycle; state stays or goes to EMPTY; nothing issues.
  - Otherwise latch instr and pc; state=HOLD.
- Latency: an instruction accepted at cycle N can assert iss_valid at cycle N+1 at the earliest.
- Source usage, from decoded_op:
  - rs1 used by every valid op except LUI_I, AUIPC_I, JAL_I.
  - rs2 used only by R-type ops, SW_I and the six branches.
- Hazard when busy[rs1]&&use_rs1, or busy[rs2]&&use_rs2, or (wr_reg && busy[rd]) (WAW).
- Hazard checks use the registered busy_vec. There is no same-cycle writeback bypass: a clear is visible one cycle later.
- iss_valid = state==HOLD && !hazard && !(wr_reg && inflight==MAX_INFLIGHT). iss_valid must not drop once asserted unless flush=1.
- On issue fire (iss_valid && iss_ready):
  - if wr_reg, set busy[rd] and increment inflight;
  - if is_br or is_jmp, next state is BR_WAIT; otherwise next state is HOLD (new accept) or EMPTY.
- On wb_valid: clear busy[wb_rd] and decrement inflight.
- Issue set and wb clear on the same register in the same cycle: set wins. Simultaneous increment and decrement leaves inflight unchanged.
- busy[0] is forced to 0 at all times.
- BR_WAIT → EMPTY on br_resolve.
- flush (highest priority over accept and issue): state=EMPTY next cycle, held instruction dropped, iss_valid=0 that same cycle. busy_vec and inflight are NOT cleared, because in-flight writes still retire.
- flush and br_resolve together: EMPTY.
- stall_cycles increments each cycle state==HOLD && !iss_valid, saturating at all-ones.
- Reset mid-operation discards everything, including busy bits.

Test Plan:
- ADDI x5,x0,1 accepted at cycle 1, iss_ready=1 → iss_valid at cycle 2, busy_vec[5]=1 at cycle 3; wb_valid rd=5 at cycle 6 → busy_vec[5]=0 at cycle 7.
- RAW: ADD x6,x5,x5 follows ADDI x5 with wb at cycle 6 → iss_valid held 0 until cycle 7; stall_cycles=4.
- In-flight limit: issue four writes to x1..x4 with no wb; fifth write x7 → iss_valid=0 and dec_ready=0. One wb (rd=1) → fifth issues the next cycle.
- BEQ x1,x2 issued → dec_ready=0 for 3 cycles until br_resolve; dec_ready=1 the cycle after.
- Flush while HOLD is stalled on x5 → iss_valid=0 immediately, state EMPTY, busy_vec[5] remains 1 until its wb.
- INVALID_I (instr=0x00000000) accepted → illegal_instr=1 for exactly one cycle, iss_valid stays 0. LUI x0 issues with busy_vec unchanged.
